avalon_mem_responder: RTL and testbench

Avalon-MM pipelined responder (slave) backed by a word-addressed on-chip RAM. It is the memory-side endpoint for the core's instruction and data Avalon masters, and is used both in simulation benches and as a small tightly-coupled memory. It supports:
- byte-enabled writes,
- fixed-latency pipelined reads,
- waitrequest backpressure (programmable stall and outstanding-read limit),
- SLVERR responses for out-of-range addresses.

---
 rtl/avalon_mem_responder.sv | 128 ++++++++++++
 tb/tb_avalon_mem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
// Avalon-MM pipelined memory responder: word-addressed RAM with byte-enabled writes,
// fixed-latency reads, programmable waitrequest stalls and SLVERR for out-of-range addresses.
module avalon_mem_responder #(
    parameter int DepthWords  = 1024,
    parameter int ReadLatency = 2,
    parameter int MaxPending  = 4,
    parameter int WaitCycles  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [1:0]  avs_response
);

    localparam int AddrBits = (DepthWords > 1) ? $clog2(DepthWords) : 1;

    logic                cmd;
    logic                accept;
    logic                rd_accept;
    logic                wr_accept;
    logic                stall;
    logic                full;
    logic                in_range;
    logic [2:0]          stall_cnt;
    logic [3:0]          pending;
    logic [AddrBits-1:0] word_idx;

    logic [31:0]            mem [DepthWords];
    logic [ReadLatency-1:0] pipe_vld;
    logic [ReadLatency-1:0] pipe_err;
    logic [31:0]            pipe_data [ReadLatency];

    assign cmd      = avs_read | avs_write;
    assign in_range = avs_address < 32'(DepthWords);
    assign word_idx = avs_address[AddrBits-1:0];

    if (WaitCycles == 0) begin : g_no_stall
        assign stall = 1'b0;
    end else begin : g_stall
        assign stall = cmd & (stall_cnt < 3'(WaitCycles));
    end

    // A returning response frees a slot in the same cycle, so a full tracker
    // still admits a new read while readdatavalid is high.
    assign full            = (pending == 4'(MaxPending)) & ~avs_readdatavalid;
    assign avs_waitrequest = rst_i | full | stall;

    assign accept    = cmd & ~avs_waitrequest;
    assign rd_accept = accept & avs_read;
    assign wr_accept = accept & avs_write & ~avs_read;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            case ({rd_accept, avs_readdatavalid})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    // Out-of-range writes are dropped rather than truncated onto a low word.
    always_ff @(posedge clk_i) begin
        if (wr_accept && in_range) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (avs_byteenable[lane]) begin
                    mem[word_idx][8*lane +: 8] <= avs_writedata[8*lane +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            for (int s = 1; s < ReadLatency; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_accept) begin
            pipe_err[0]  <= ~in_range;
            pipe_data[0] <= in_range ? mem[word_idx] : 32'h0;
        end
        for (int s = 1; s < ReadLatency; s++) begin
            pipe_err[s]  <= pipe_err[s-1];
            pipe_data[s] <= pipe_data[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            avs_response      <= 2'b00;
        end else begin
            avs_readdatavalid <= pipe_vld[ReadLatency-1];
            if (pipe_vld[ReadLatency-1]) begin
                avs_readdata <= pipe_data[ReadLatency-1];
                avs_response <= pipe_err[ReadLatency-1] ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: memory/response scoreboard on the default instance,
// directed timing checks on a stalling instance and an outstanding-limited instance.
module tb_avalon_mem_responder;

    localparam int MainLat  = 2;
    localparam int MainPend = 4;
    localparam int Depth    = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic [3:0]  a_be = '0;
    logic        a_rd = 1'b0, a_wr = 1'b0, a_wait, a_rdv;
    logic [1:0]  a_resp;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic [3:0]  b_be = '0;
    logic        b_rd = 1'b0, b_wr = 1'b0, b_wait, b_rdv;
    logic [1:0]  b_resp;
    logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic [3:0]  c_be = '0;
    logic        c_rd = 1'b0, c_wr = 1'b0, c_wait, c_rdv;
    logic [1:0]  c_resp;

    avalon_mem_responder u_dut (
        .clk_i(clk), .rst_i(rst), .avs_address(a_addr), .avs_byteenable(a_be),
        .avs_read(a_rd), .avs_write(a_wr), .avs_writedata(a_wdata),
        .avs_waitrequest(a_wait), .avs_readdata(a_rdata),
        .avs_readdatavalid(a_rdv), .avs_response(a_resp)
    );

    avalon_mem_responder #(.WaitCycles(2)) u_wait (
        .clk_i(clk), .rst_i(rst), .avs_address(b_addr), .avs_byteenable(b_be),
        .avs_read(b_rd), .avs_write(b_wr), .avs_writedata(b_wdata),
        .avs_waitrequest(b_wait), .avs_readdata(b_rdata),
        .avs_readdatavalid(b_rdv), .avs_response(b_resp)
    );

    avalon_mem_responder #(.MaxPending(1), .ReadLatency(3)) u_pend (
        .clk_i(clk), .rst_i(rst), .avs_address(c_addr), .avs_byteenable(c_be),
        .avs_read(c_rd), .avs_write(c_wr), .avs_writedata(c_wdata),
        .avs_waitrequest(c_wait), .avs_readdata(c_rdata),
        .avs_readdatavalid(c_rdv), .avs_response(c_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model for the default instance: RAM contents plus an ordered list of
    // responses owed, each tagged with the cycle it must appear in.
    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          known;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mmem[int];
    bit          chk_on = 1'b0;
    logic [31:0] last_data;
    logic [1:0]  last_resp;
    int          last_rdv_cyc;
    logic [31:0] rlog[$];
    int          rlog_cyc[$];

    always @(negedge clk) begin : model_proc
        rsp_t        e;
        bit          exp_rdv;
        bit          exp_wait;
        logic [31:0] mask;
        if (chk_on) begin
            exp_rdv  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            exp_wait = rst || ((exp_q.size() == MainPend) && !exp_rdv);
            chk("waitrequest", a_wait, exp_wait);
            chk("readdatavalid", a_rdv, exp_rdv);
            if (exp_rdv) begin
                e = exp_q.pop_front();
                if (a_rdv) begin
                    if (e.known) chk("readdata", a_rdata, e.data);
                    chk("response", a_resp, e.resp);
                    last_data    = a_rdata;
                    last_resp    = a_resp;
                    last_rdv_cyc = cyc;
                    rlog.push_back(a_rdata);
                    rlog_cyc.push_back(cyc);
                end
            end
            if (rst) begin
                exp_q.delete();
            end else if ((a_rd || a_wr) && !a_wait) begin
                if (a_rd) begin
                    e.due = cyc + 1 + MainLat;
                    if (a_addr >= Depth) begin
                        e.data = 32'h0; e.resp = 2'b10; e.known = 1'b1;
                    end else begin
                        e.resp  = 2'b00;
                        e.known = mmem.exists(int'(a_addr));
                        e.data  = e.known ? mmem[int'(a_addr)] : 32'h0;
                    end
                    exp_q.push_back(e);
                end else if (a_addr < Depth) begin
                    mask = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};
                    if (mmem.exists(int'(a_addr)))
                        mmem[int'(a_addr)] = (mmem[int'(a_addr)] & ~mask) | (a_wdata & mask);
                    else if (a_be == 4'hF)
                        mmem[int'(a_addr)] = a_wdata;
                end
            end
        end
    end

    logic [31:0] b_log[$], c_log[$];
    int          b_cyc[$], c_cyc[$];
    always @(negedge clk) begin
        if (b_rdv) begin b_log.push_back(b_rdata); b_cyc.push_back(cyc); end
        if (c_rdv) begin c_log.push_back(c_rdata); c_cyc.push_back(cyc); end
    end

    function automatic logic wait_of(input int w);
        case (w)
            0:       return a_wait;
            1:       return b_wait;
            default: return c_wait;
        endcase
    endfunction

    task automatic set_cmd(input int w, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        case (w)
            0:       begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd; a_be = be; end
            1:       begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd; b_be = be; end
            default: begin c_rd = rd; c_wr = wr; c_addr = addr; c_wdata = wd; c_be = be; end
        endcase
    endtask

    // Present a command and hold it until accepted; returns stall count and acceptance edge.
    task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int stalls, output int acc);
        int n = 0;
        set_cmd(w, rd, wr, addr, wd, be);
        forever begin
            @(negedge clk);
            if (!wait_of(w)) break;
            n++;
            if (n > 40) begin
                chk("accept_timeout", wait_of(w), 1'b0);
                break;
            end
        end
        stalls = n;
        acc    = cyc + 1;
        @(posedge clk); #1;
        set_cmd(w, 1'b0, 1'b0, addr, wd, be);
    endtask

    int st, ac, st_sum, acc1, acc2, nlog;

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        drive(0, 1'b0, 1'b1, addr, wd, be, st, ac);
    endtask

    task automatic rd_a(input logic [31:0] addr);
        drive(0, 1'b1, 1'b0, addr, 32'h0, 4'h0, st, ac);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdv", a_rdv, 1'b0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_resp", a_resp, 2'b00);
        chk("rst_wait", a_wait, 1'b1);
        chk("rst_wait_b", b_wait, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", a_wait, 1'b0);
        chk("post_rst_wait_b", b_wait, 1'b0);
        chk("post_rst_wait_c", c_wait, 1'b0);
        chk_on = 1'b1;
        @(posedge clk); #1;

        // full write then read-after-write on the next edge
        wr_a(32'd5, 32'hDEADBEEF, 4'hF);
        rd_a(32'd5);
        acc1 = ac;
        drain();
        chk("lit_rd5_data", last_data, 32'hDEADBEEF);
        chk("lit_rd5_resp", last_resp, 2'b00);
        chk("lit_rd5_latency", last_rdv_cyc - acc1, 2);

        // byte enables
        wr_a(32'd6, 32'h00000000, 4'hF);
        wr_a(32'd6, 32'h11223344, 4'b0101);
        rd_a(32'd6);
        drain();
        chk("lit_be_data", last_data, 32'h00220044);

        // read and write together: treated as a read, write dropped
        drive(0, 1'b1, 1'b1, 32'd6, 32'hFFFFFFFF, 4'hF, st, ac);
        rd_a(32'd6);
        drain();
        chk("lit_rw_data", last_data, 32'h00220044);

        // back-to-back pipelined reads
        for (int i = 1; i <= 4; i++) wr_a(i, 32'hA0000000 + i, 4'hF);
        rlog.delete(); rlog_cyc.delete();
        st_sum = 0;
        for (int i = 1; i <= 4; i++) begin
            rd_a(i);
            st_sum += st;
        end
        drain();
        chk("lit_pipe_stalls", st_sum, 0);
        chk("lit_pipe_count", rlog.size(), 4);
        if (rlog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("lit_pipe_order", rlog[i], 32'hA0000001 + i);
            for (int i = 1; i < 4; i++) chk("lit_pipe_gap", rlog_cyc[i] - rlog_cyc[i-1], 1);
        end

        // out-of-range writes must not alias; out-of-range read errors
        wr_a(32'd0, 32'h12345678, 4'hF);
        wr_a(32'd1024, 32'hFFFFFFFF, 4'hF);
        wr_a(32'd1029, 32'hFFFFFFFF, 4'hF);
        wr_a(32'h80000000, 32'hFFFFFFFF, 4'hF);
        rlog.delete(); rlog_cyc.delete();
        rd_a(32'd0);
        rd_a(32'd5);
        rd_a(32'd1024);
        drain();
        chk("lit_oor_count", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("lit_oor_addr0", rlog[0], 32'h12345678);
            chk("lit_oor_addr5", rlog[1], 32'hDEADBEEF);
            chk("lit_oor_rdata", rlog[2], 32'h0);
        end
        chk("lit_oor_resp", last_resp, 2'b10);

        // reset right after a read is accepted drops it
        rd_a(32'd5);
        rst = 1'b1;
        nlog = rlog.size();
        @(negedge clk);
        chk("lit_rst_wait", a_wait, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("lit_rst_dropped", rlog.size(), nlog);
        rd_a(32'd5);
        drain();
        chk("lit_rst_rd5", last_data, 32'hDEADBEEF);

        // WaitCycles=2: every command sees two stall cycles
        drive(1, 1'b0, 1'b1, 32'd3, 32'hCAFEF00D, 4'hF, st, ac);
        chk("lit_wc_wr_stalls", st, 2);
        drive(1, 1'b1, 1'b0, 32'd3, 32'h0, 4'h0, st, ac);
        chk("lit_wc_rd_stalls", st, 2);
        acc1 = ac;
        repeat (4) @(posedge clk);
        #1;
        chk("lit_wc_count", b_log.size(), 1);
        if (b_log.size() == 1) begin
            chk("lit_wc_data", b_log[0], 32'hCAFEF00D);
            chk("lit_wc_latency", b_cyc[0] - acc1, 2);
        end
        chk("lit_wc_resp", b_resp, 2'b00);

        // MaxPending=1, ReadLatency=3: second read waits for the first response
        drive(2, 1'b0, 1'b1, 32'd9, 32'h00000099, 4'hF, st, ac);
        drive(2, 1'b0, 1'b1, 32'd10, 32'h000000AA, 4'hF, st, ac);
        drive(2, 1'b1, 1'b0, 32'd9, 32'h0, 4'h0, st, ac);
        chk("lit_mp_first_stalls", st, 0);
        acc1 = ac;
        drive(2, 1'b1, 1'b0, 32'd10, 32'h0, 4'h0, st, ac);
        chk("lit_mp_second_stalls", st, 3);
        acc2 = ac;
        chk("lit_mp_second_acc", acc2 - acc1, 4);
        repeat (5) @(posedge clk);
        #1;
        chk("lit_mp_count", c_log.size(), 2);
        if (c_log.size() == 2) begin
            chk("lit_mp_data0", c_log[0], 32'h00000099);
            chk("lit_mp_data1", c_log[1], 32'h000000AA);
            chk("lit_mp_rdv0", c_cyc[0] - acc1, 3);
            chk("lit_mp_acc_on_rdv", acc2 - c_cyc[0], 1);
            chk("lit_mp_rdv1", c_cyc[1] - acc2, 3);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
